// File: rtl/mpe_ctl.sv
// mpe_ctl: uop sequencer for matrix_pe; streams NRAM/WRAM beat pairs through 2-entry skid FIFOs.
// Optional WAIT_RES watchdog is built in when MPE_CTL_TIMEOUT_EN is defined.
module mpe_ctl #(
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 512,
   parameter int unsigned RW      = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    ib_uop,
   input  logic          ib_uop_valid,
   output logic          ib_uop_ready,
   output logic [7:0]    mpe_uop,
   output logic          mpe_uop_valid,
   input  logic          mpe_uop_ready,
   output logic          nram_rd_en,
   output logic [AW-1:0] nram_rd_addr,
   input  logic [DW-1:0] nram_rd_data,
   output logic          wram_rd_en,
   output logic [AW-1:0] wram_rd_addr,
   input  logic [DW-1:0] wram_rd_data,
   output logic [DW-1:0] mpe_neuron,
   output logic          mpe_neuron_valid,
   input  logic          mpe_neuron_ready,
   output logic [DW-1:0] mpe_weight,
   output logic          mpe_weight_valid,
   input  logic          mpe_weight_ready,
   input  logic [RW-1:0] mpe_result,
   input  logic          mpe_vld_o,
   output logic [RW-1:0] res_data,
   output logic          res_valid,
   output logic          busy,
   output logic [15:0]   inst_cnt,
   output logic          err
);
   typedef enum logic [1:0] {IDLE, ISSUE, STREAM, WAIT_RES} state_t;

   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("mpe_ctl: TIMEOUT must be nonzero");
   end

   state_t        state_q;
   logic [7:0]    n_q;
   logic [7:0]    uop_q;
   logic          ib_rdy_q;
   logic          uop_vld_q;
   logic          res_vld_q;
   logic          err_q;
   logic [RW-1:0] res_q;
   logic [15:0]   cnt_inst_q;

   // Stream index 0 is neuron (NRAM), 1 is weight (WRAM).
   logic [AW-1:0] ptr_q    [2];
   logic [7:0]    issued_q [2];
   logic [7:0]    popped_q [2];
   logic [1:0]    fcnt_q   [2];
   logic [DW-1:0] fifo_q   [2][2];
   logic [1:0]    inflight_q;
   logic [1:0]    wp_q;
   logic [1:0]    rp_q;

`ifdef MPE_CTL_TIMEOUT_EN
   logic [31:0]   tmo_q;
`endif

   logic [DW-1:0] rdata [2];
   logic [1:0]    srdy;
   logic [1:0]    svld;
   logic [1:0]    pop;
   logic [1:0]    rd_en;
   logic          done;
   logic          vld_legal;

   always_comb begin
      rdata[0] = nram_rd_data;
      rdata[1] = wram_rd_data;
      srdy     = {mpe_weight_ready, mpe_neuron_ready};
      svld     = '0;
      pop      = '0;
      rd_en    = '0;
      for (int unsigned s = 0; s < 2; s++) begin
         svld[s]  = (fcnt_q[s] != 2'd0);
         pop[s]   = svld[s] & srdy[s];
         // A pop this cycle frees a slot, so the refill read may overlap it (1 beat/cycle).
         rd_en[s] = (state_q == STREAM) && (issued_q[s] < n_q) &&
                    (((({1'b0, fcnt_q[s]}) + {2'b00, inflight_q[s]}) < 3'd2) || pop[s]);
      end
      done      = (state_q == STREAM) && (popped_q[0] == n_q) && (popped_q[1] == n_q);
      vld_legal = (state_q == WAIT_RES) || done;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         n_q        <= '0;
         uop_q      <= '0;
         ib_rdy_q   <= 1'b0;
         uop_vld_q  <= 1'b0;
         res_vld_q  <= 1'b0;
         err_q      <= 1'b0;
         res_q      <= '0;
         cnt_inst_q <= '0;
         inflight_q <= '0;
         wp_q       <= '0;
         rp_q       <= '0;
         for (int unsigned s = 0; s < 2; s++) begin
            ptr_q[s]     <= '0;
            issued_q[s]  <= '0;
            popped_q[s]  <= '0;
            fcnt_q[s]    <= '0;
            fifo_q[s][0] <= '0;
            fifo_q[s][1] <= '0;
         end
`ifdef MPE_CTL_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         res_vld_q  <= 1'b0;
         inflight_q <= rd_en;
         if (mpe_vld_o && !vld_legal) err_q <= 1'b1;

         for (int unsigned s = 0; s < 2; s++) begin
            if (rd_en[s]) begin
               ptr_q[s]    <= ptr_q[s] + AW'(1);
               issued_q[s] <= issued_q[s] + 8'd1;
            end
            if (inflight_q[s]) begin
               fifo_q[s][wp_q[s]] <= rdata[s];
               wp_q[s]            <= ~wp_q[s];
            end
            if (pop[s]) begin
               rp_q[s]     <= ~rp_q[s];
               popped_q[s] <= popped_q[s] + 8'd1;
            end
            case ({inflight_q[s], pop[s]})
               2'b10:   fcnt_q[s] <= fcnt_q[s] + 2'd1;
               2'b01:   fcnt_q[s] <= fcnt_q[s] - 2'd1;
               default: ;
            endcase
         end

`ifdef MPE_CTL_TIMEOUT_EN
         if (state_q != WAIT_RES) tmo_q <= '0;
`endif

         if (mpe_vld_o && vld_legal) begin
            res_q      <= mpe_result;
            res_vld_q  <= 1'b1;
            cnt_inst_q <= cnt_inst_q + 16'd1;
            ib_rdy_q   <= 1'b1;
            state_q    <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  ib_rdy_q <= 1'b1;
                  if (ib_rdy_q && ib_uop_valid) begin
                     if (ib_uop == 8'd0) begin
                        cnt_inst_q <= cnt_inst_q + 16'd1;
                     end else begin
                        n_q         <= ib_uop;
                        uop_q       <= ib_uop;
                        uop_vld_q   <= 1'b1;
                        ib_rdy_q    <= 1'b0;
                        issued_q[0] <= '0;
                        issued_q[1] <= '0;
                        popped_q[0] <= '0;
                        popped_q[1] <= '0;
                        state_q     <= ISSUE;
                     end
                  end
               end
               ISSUE: begin
                  if (mpe_uop_ready) begin
                     uop_vld_q <= 1'b0;
                     state_q   <= STREAM;
                  end
               end
               STREAM: begin
                  if (done) state_q <= WAIT_RES;
               end
               WAIT_RES: begin
`ifdef MPE_CTL_TIMEOUT_EN
                  if (tmo_q == TIMEOUT - 1) begin
                     err_q    <= 1'b1;
                     ib_rdy_q <= 1'b1;
                     state_q  <= IDLE;
                  end else begin
                     tmo_q <= tmo_q + 32'd1;
                  end
`endif
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ib_uop_ready     = ib_rdy_q;
   assign mpe_uop          = uop_q;
   assign mpe_uop_valid    = uop_vld_q;
   assign nram_rd_en       = rd_en[0];
   assign nram_rd_addr     = ptr_q[0];
   assign wram_rd_en       = rd_en[1];
   assign wram_rd_addr     = ptr_q[1];
   assign mpe_neuron       = fifo_q[0][rp_q[0]];
   assign mpe_neuron_valid = svld[0];
   assign mpe_weight       = fifo_q[1][rp_q[1]];
   assign mpe_weight_valid = svld[1];
   assign res_data         = res_q;
   assign res_valid        = res_vld_q;
   assign busy             = (state_q != IDLE);
   assign inst_cnt         = cnt_inst_q;
   assign err              = err_q;

endmodule
